// File: rtl/delay_code_ctrl_pkg.sv
// Shared types and default constants for the delay-code controller.
//   state_e      : controller FSM states
//   cal_phase_e  : where a slew sits relative to calibration (none/before sweep/after sweep)
//   DELAY_WIDTH_DEF, SETTLE_CYCLES_DEF : default parameter values
//   SETTLE_CNT_W : settle counter width, wide enough for any legal SettleCycles (1..255)
package delay_code_ctrl_pkg;

  localparam int unsigned DELAY_WIDTH_DEF   = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 8;
  localparam int unsigned SETTLE_CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLEW,
    ST_SETTLE,
    ST_CAL_SETTLE,
    ST_CAL_SAMPLE,
    ST_CAL_END
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_PRE,
    PH_POST
  } cal_phase_e;

endpackage

// File: rtl/delay_settle_cnt.sv
// Settle down-counter shared by the manual and calibration settle windows.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load count_i (takes priority over counting)
//   count_i       : value loaded on load_i
//   zero_o        : counter is at zero; the counter holds at zero
module delay_settle_cnt
  import delay_code_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [SETTLE_CNT_W-1:0] count_i,
  output logic                    zero_o
);

  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = count_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delay_code_ctrl.sv
// Delay-line tap code controller: slews delay_o one LSB at a time toward a
// manual target or a calibrated mid-window code, settling after every step.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   cfg_valid_i/cfg_code_i   : manual target offer; cfg_ready_o accepts it in IDLE
//   cal_start_i              : calibration request (IDLE only, wins over cfg)
//   sample_ok_i              : capture-path pass/fail probe used during the sweep
//   delay_o, enable_o        : delay line code and enable (both flop outputs)
//   busy_o                   : not IDLE
//   cal_done_o, cal_fail_o   : calibration end pulse, sticky no-pass flag
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_IDLE       | waiting for a cfg handshake or a calibration request
// ST_SLEW       | step delay_o one LSB toward target, or arrive if already there
// ST_SETTLE     | hold the new code until the settle counter reaches zero
// ST_CAL_SETTLE | sweep: hold the current code for SettleCycles cycles
// ST_CAL_SAMPLE | sweep: sample sample_ok_i, then advance or end the sweep
// ST_CAL_END    | pick the mid-window code (or the saved code) and slew there
module delay_code_ctrl
  import delay_code_ctrl_pkg::*;
#(
  parameter int unsigned DelayWidth   = DELAY_WIDTH_DEF,
  parameter int unsigned SettleCycles = SETTLE_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  input  logic [DelayWidth-1:0] cfg_code_i,
  output logic                  cfg_ready_o,
  input  logic                  cal_start_i,
  input  logic                  sample_ok_i,
  output logic [DelayWidth-1:0] delay_o,
  output logic                  enable_o,
  output logic                  busy_o,
  output logic                  cal_done_o,
  output logic                  cal_fail_o
);

  localparam logic [DelayWidth-1:0]   TopCode    = '1;
  localparam logic [DelayWidth-1:0]   OneCode    = {{(DelayWidth-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_CNT_W-1:0] SettleLoad = SETTLE_CNT_W'(SettleCycles - 1);

  state_e                state_q;
  cal_phase_e            phase_q;
  logic [DelayWidth-1:0] delay_q, target_q, saved_q, first_q, last_q;
  logic                  found_q, enable_q, cal_done_q, cal_fail_q;

  logic                  cnt_load, cnt_zero;
  logic                  at_target, idle_rdy, arrive_pre, sweep_end;
  logic [DelayWidth:0]   mid_sum;

  assign at_target  = (delay_q == target_q);
  assign idle_rdy   = (state_q == ST_IDLE) && enable_q;
  assign arrive_pre = (phase_q == PH_PRE);
  // The window is open exactly while found_q is set, since the first fail
  // after a pass ends the sweep.
  assign sweep_end  = (delay_q == TopCode) || (!sample_ok_i && found_q);
  assign mid_sum    = {1'b0, first_q} + {1'b0, last_q};

  always_comb begin
    cnt_load = 1'b0;
    unique case (state_q)
      ST_SLEW:       cnt_load = !at_target || arrive_pre;
      ST_SETTLE:     cnt_load = cnt_zero && at_target && arrive_pre;
      ST_CAL_SAMPLE: cnt_load = !sweep_end;
      default:       cnt_load = 1'b0;
    endcase
  end

  delay_settle_cnt u_settle_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (cnt_load),
    .count_i (SettleLoad),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_NONE;
      delay_q    <= '0;
      target_q   <= '0;
      saved_q    <= '0;
      first_q    <= '0;
      last_q     <= '0;
      found_q    <= 1'b0;
      enable_q   <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
    end else begin
      enable_q   <= 1'b1;
      cal_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (idle_rdy && cal_start_i) begin
            saved_q    <= delay_q;
            target_q   <= '0;
            phase_q    <= PH_PRE;
            found_q    <= 1'b0;
            cal_fail_q <= 1'b0;
            state_q    <= ST_SLEW;
          end else if (idle_rdy && cfg_valid_i) begin
            target_q <= cfg_code_i;
            state_q  <= ST_SLEW;
          end
        end
        ST_SLEW: begin
          if (!at_target) begin
            delay_q <= (delay_q < target_q) ? delay_q + OneCode : delay_q - OneCode;
            state_q <= ST_SETTLE;
          end else begin
            state_q <= arrive_pre ? ST_CAL_SETTLE : ST_IDLE;
            if (phase_q == PH_POST) cal_done_q <= 1'b1;
            if (!arrive_pre) phase_q <= PH_NONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            if (!at_target) begin
              state_q <= ST_SLEW;
            end else begin
              state_q <= arrive_pre ? ST_CAL_SETTLE : ST_IDLE;
              if (phase_q == PH_POST) cal_done_q <= 1'b1;
              if (!arrive_pre) phase_q <= PH_NONE;
            end
          end
        end
        ST_CAL_SETTLE: begin
          if (cnt_zero) state_q <= ST_CAL_SAMPLE;
        end
        ST_CAL_SAMPLE: begin
          if (sample_ok_i) begin
            if (!found_q) first_q <= delay_q;
            found_q <= 1'b1;
            last_q  <= delay_q;
          end
          if (sweep_end) begin
            state_q <= ST_CAL_END;
          end else begin
            delay_q <= delay_q + OneCode;
            state_q <= ST_CAL_SETTLE;
          end
        end
        ST_CAL_END: begin
          phase_q <= PH_POST;
          state_q <= ST_SLEW;
          if (found_q) begin
            target_q <= mid_sum[DelayWidth:1];
          end else begin
            target_q   <= saved_q;
            cal_fail_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign delay_o     = delay_q;
  assign enable_o    = enable_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cal_done_o  = cal_done_q;
  assign cal_fail_o  = cal_fail_q;
  // Calibration wins over a simultaneous cfg offer, so ready drops with cal_start_i.
  assign cfg_ready_o = idle_rdy && !cal_start_i;

endmodule
